// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder model: read-FSM encoding,
// error-cause codes, bus width and counter saturation helper.
package sram_pkg;

    localparam int          DATA_W  = 16;
    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_VALID  = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_EMPTY_LANE = 2'd1,
        ERR_ALIAS      = 2'd2
    } err_code_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sram_resp_array.sv
// Byte-lane writable word storage with an asynchronous read port.
// Contents are deliberately not reset: the modelled chip loses nothing on rst.
module sram_resp_array
    import sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [1:0]            wr_lane,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    // wr_lane[1] selects [15:8], wr_lane[0] selects [7:0]
    always_ff @(posedge clk) begin
        if (wr_lane[1]) mem[wr_addr][15:8] <= wr_data[15:8];
        if (wr_lane[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sram_resp_model.sv
// Device-side responder for the 256Kx16 external SRAM bus with programmable
// read latency and traffic counters. Define SRAM_RESP_CHK_EN to build the protocol checker.
module sram_resp_model
    import sram_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int DEPTH_LOG2 = 16,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_adr,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              err,
    output logic [1:0]        err_code,
    output rd_state_t         dbg_state
);

    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    rd_state_t         state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] adr_q, adr_nx;
    logic [DATA_W-1:0] rd_reg, mem_rdata;
    logic              rd_load;
    logic              rd_cond, wr_cond;
    logic [1:0]        wr_lane;
    logic              drive_ub, drive_lb;

    assign rd_cond = ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
    assign wr_cond = ~SRAM_CE_N & ~SRAM_WE_N;
    assign wr_lane = {wr_cond & ~SRAM_UB_N, wr_cond & ~SRAM_LB_N};

    sram_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .wr_addr (SRAM_adr[DEPTH_LOG2-1:0]),
        .wr_lane (wr_lane),
        .wr_data (SRAM_DQ),
        .rd_addr (SRAM_adr[DEPTH_LOG2-1:0]),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            rd_reg   <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            adr_q <= adr_nx;
            if (rd_load) begin
                rd_reg   <= mem_rdata;
                rd_count <= sat_inc(rd_count);
            end
            if (wr_cond) wr_count <= sat_inc(wr_count);
        end
    end

    // Any write edge also drops the read condition, so it returns to IDLE and
    // the next read re-fetches the word.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        adr_nx   = adr_q;
        rd_load  = 1'b0;
        if (!rd_cond) begin
            state_nx = ST_IDLE;
        end else if (state == ST_IDLE || SRAM_adr != adr_q) begin
            adr_nx = SRAM_adr;
            cnt_nx = LAT_M1;
            if (READ_LAT == 1) begin
                state_nx = ST_VALID;
                rd_load  = 1'b1;
            end else begin
                state_nx = ST_ACCESS;
            end
        end else if (state == ST_ACCESS) begin
            // The edge on which cnt reaches zero is the fetch edge.
            if (cnt <= 2'd1) begin
                cnt_nx   = '0;
                state_nx = ST_VALID;
                rd_load  = 1'b1;
            end else begin
                cnt_nx = cnt - 2'd1;
            end
        end
    end

    always_comb begin
        drive_ub = 1'b0;
        drive_lb = 1'b0;
        if (state == ST_VALID && rd_cond && SRAM_adr == adr_q) begin
            drive_ub = ~SRAM_UB_N;
            drive_lb = ~SRAM_LB_N;
        end
    end

    assign SRAM_DQ[15:8] = drive_ub ? rd_reg[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = drive_lb ? rd_reg[7:0]  : 8'hzz;
    assign dbg_state     = state;

`ifdef SRAM_RESP_CHK_EN
    logic empty_lane, aliased;

    assign empty_lane = wr_cond & SRAM_UB_N & SRAM_LB_N;
    assign aliased    = ~SRAM_CE_N & (|SRAM_adr[ADDR_W-1:DEPTH_LOG2]);

    // First cause is held; empty-lane outranks aliasing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (!err) begin
            if (empty_lane) begin
                err      <= 1'b1;
                err_code <= ERR_EMPTY_LANE;
            end else if (aliased) begin
                err      <= 1'b1;
                err_code <= ERR_ALIAS;
            end
        end
    end
`else
    assign err      = 1'b0;
    assign err_code = ERR_NONE;
`endif

endmodule
